// File: rtl/imem_loader.sv
// imem_loader: byte-stream writer for the 16-bit word-addressed instruction memory; holds the CPU while loading.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
`default_nettype none

module imem_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN_HI  = 3'd1,
      S_LEN_LO  = 3'd2,
      S_DATA_HI = 3'd3,
      S_DATA_LO = 3'd4,
      S_CHK     = 3'd5,
      S_DONE    = 3'd6,
      S_ERR     = 3'd7
   } state_t;

   localparam logic [15:0] DEPTH16 = 16'(DEPTH);

   state_t            state;
   logic [7:0]        len_hi;
   logic [7:0]        data_hi;
   logic [ADDR_W:0]   n_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   logic              xfer;
   logic [15:0]       len_full;
   logic [ADDR_W:0]   next_count;
   logic              last_word;

   assign xfer       = byte_valid & byte_ready;
   assign len_full   = {len_hi, byte_data};
   assign next_count = words_loaded + {{ADDR_W{1'b0}}, 1'b1};
   assign last_word  = (next_count == n_words);

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_IDLE;
         byte_ready   <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cpu_hold     <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
         len_hi       <= '0;
         data_hi      <= '0;
         n_words      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state        <= S_LEN_HI;
                  byte_ready   <= 1'b1;
                  cpu_hold     <= 1'b1;
                  error        <= 1'b0;
                  words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum         <= '0;
`endif
               end
            end
            S_LEN_HI: begin
               if (xfer) begin
                  len_hi <= byte_data;
                  state  <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (xfer) begin
                  if (len_full == 16'd0) begin
                     state      <= S_DONE;
                     done       <= 1'b1;
                     cpu_hold   <= 1'b0;
                     byte_ready <= 1'b0;
                  end else if (len_full > DEPTH16) begin
                     state      <= S_ERR;
                     error      <= 1'b1;
                     cpu_hold   <= 1'b0;
                     byte_ready <= 1'b0;
                  end else begin
                     n_words <= len_full[ADDR_W:0];
                     state   <= S_DATA_HI;
                  end
               end
            end
            S_DATA_HI: begin
               if (xfer) begin
                  data_hi <= byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum    <= csum ^ byte_data;
`endif
                  state   <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (xfer) begin
                  // Write lands one cycle after the low byte; index advances with it.
                  mem_we       <= 1'b1;
                  mem_addr     <= words_loaded[ADDR_W-1:0];
                  mem_wdata    <= {data_hi, byte_data};
                  words_loaded <= next_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum         <= csum ^ byte_data;
`endif
                  if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state      <= S_CHK;
`else
                     state      <= S_DONE;
                     done       <= 1'b1;
                     cpu_hold   <= 1'b0;
                     byte_ready <= 1'b0;
`endif
                  end else begin
                     state <= S_DATA_HI;
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (xfer) begin
                  cpu_hold   <= 1'b0;
                  byte_ready <= 1'b0;
                  if (byte_data == csum) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state      <= S_IDLE;
               byte_ready <= 1'b0;
               cpu_hold   <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed streams; expected writes queued by stimulus and popped by a write monitor.
`default_nettype none

module tb_imem_loader;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 1024;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data = 8'h00;
   logic              byte_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   int n_vec = 0;
   int n_err = 0;

   logic [25:0] exp_q[$];
   logic [15:0] wv[8];
   logic [7:0]  cs;

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (mem_we) begin
         logic [25:0] e;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: got addr=%0h data=%04h, none expected", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata} !== e) begin
               n_err++;
               $display("FAIL write: got addr=%0h data=%04h, want addr=%0h data=%04h",
                        mem_addr, mem_wdata, e[25:16], e[15:0]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int t = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (t >= 50) check("byte_ready_timeout", 32'd0, 32'd1);
      else @(negedge clock);
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Sends n words from wv, queueing the expected writes from address 0.
   task automatic stream_words(input int n, input bit gap);
      cs = 8'h00;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({10'(i), wv[i]});
         cs = cs ^ wv[i][15:8] ^ wv[i][7:0];
         send(wv[i][15:8]);
         if (gap) begin
            @(negedge clock);
            check("ready_in_gap_hi", 32'(byte_ready), 32'd1);
         end
         send(wv[i][7:0]);
         if (gap && i != n - 1) begin
            @(negedge clock);
            check("ready_in_gap_lo", 32'(byte_ready), 32'd1);
         end
      end
   endtask

   task automatic finish_stream();
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(cs);
`endif
   endtask

   task automatic check_done(input int nw);
      check("done_pulse", 32'(done), 32'd1);
      check("hold_released", 32'(cpu_hold), 32'd0);
      check("words_loaded", 32'(words_loaded), 32'(nw));
      check("error_clear", 32'(error), 32'd0);
      @(negedge clock);
      check("done_one_cycle", 32'(done), 32'd0);
      check("ready_low_done", 32'(byte_ready), 32'd0);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      check("rst_ready", 32'(byte_ready), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Basic two-word load, with an ignored start mid-stream.
      pulse_start();
      check("hold_after_start", 32'(cpu_hold), 32'd1);
      check("ready_after_start", 32'(byte_ready), 32'd1);
      send(8'h00); send(8'h02);
      pulse_start();
      wv[0] = 16'h700F; wv[1] = 16'h7207;
      stream_words(2, 1'b0);
      finish_stream();
      check_done(2);

      // Same stream with byte_valid low every other cycle.
      pulse_start();
      send(8'h00); @(negedge clock); send(8'h02); @(negedge clock);
      stream_words(2, 1'b1);
      finish_stream();
      check_done(2);

      // Zero-length load.
      pulse_start();
      send(8'h00); send(8'h00);
      check("n0_we", 32'(mem_we), 32'd0);
      check_done(0);

      // Oversize length goes to ERR, ignores bytes, recovers on start.
      pulse_start();
      send(8'h04); send(8'h01);
      check("err_set", 32'(error), 32'd1);
      check("err_hold", 32'(cpu_hold), 32'd0);
      check("err_ready", 32'(byte_ready), 32'd0);
      check("err_we", 32'(mem_we), 32'd0);
      byte_valid = 1'b1; byte_data = 8'hFF;
      repeat (3) @(negedge clock);
      byte_valid = 1'b0;
      check("err_sticky", 32'(error), 32'd1);
      pulse_start();
      check("err_cleared", 32'(error), 32'd0);
      send(8'h00); send(8'h01);
      wv[0] = 16'hBEEF;
      stream_words(1, 1'b0);
      finish_stream();
      check_done(1);

      // Reset after 3 of 5 words, then reload.
      pulse_start();
      send(8'h00); send(8'h05);
      wv[0] = 16'h1111; wv[1] = 16'h2222; wv[2] = 16'h3333;
      stream_words(3, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("mid_rst_we", 32'(mem_we), 32'd0);
      check("mid_rst_addr", 32'(mem_addr), 32'd0);
      check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
      check("mid_rst_hold", 32'(cpu_hold), 32'd0);
      check("mid_rst_ready", 32'(byte_ready), 32'd0);
      check("mid_rst_words", 32'(words_loaded), 32'd0);
      check("mid_rst_q", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clock);
      pulse_start();
      send(8'h00); send(8'h02);
      wv[0] = 16'hAAAA; wv[1] = 16'h5555;
      stream_words(2, 1'b0);
      finish_stream();
      check_done(2);

`ifdef IMEM_LOADER_CHECKSUM_EN
      pulse_start();
      send(8'h00); send(8'h01);
      wv[0] = 16'h1234;
      stream_words(1, 1'b0);
      send(8'h26);
      check_done(1);

      pulse_start();
      send(8'h00); send(8'h01);
      stream_words(1, 1'b0);
      send(8'h00);
      check("chk_bad_err", 32'(error), 32'd1);
      check("chk_bad_done", 32'(done), 32'd0);
      check("chk_bad_q", 32'(exp_q.size()), 32'd0);
`endif

      repeat (3) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

`default_nettype wire
